cla_pipe_addsub: RTL and testbench
==================================

Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit CLA used in the ALU datapath.
- Splits a WIDTH-bit operation into 16-bit CLA segments, one segment per pipeline stage; the carry between segments is registered.
- Adds subtract mode, status flags and a valid/ready handshake so the ALU can issue one operation per cycle at higher clock rates.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 16 and at least 16.
- SEG, 16, segment width per stage; fixed at 16 (each stage uses one 16-bit four-group CLA with a lookahead unit).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands on a, b and sub are valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = a+b+c_in; 1 = a-b (computed as a + ~b + 1; c_in is ignored).
- c_in  input  1  carry-in for add mode.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of bit WIDTH-1; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Behaviour:
- Reset:
  - rst_n sampled low at a clock edge clears every stage valid bit; out_valid=0.
  - sum, c_out, ovf, zero and neg all read 0.
  - The pipeline data registers are also cleared.
  - Reset mid-operation discards every in-flight operation; no partial result is emitted.
  - in_ready = 1 in the first cycle after rst_n returns high.
- Latency and stages:
  - NS = WIDTH/16 stages; latency = NS cycles from the accepting edge to out_valid.
  - Stage k (0..NS-1) computes bits [16k+15:16k] using the registered carry from stage k-1.
  - Stage 0 carry-in = sub ? 1 : c_in.
  - b is inverted on capture when sub=1.
- Skew and deskew:
  - Operand bits for later segments travel in skew registers until their stage.
  - Completed sum segments travel in deskew registers so the full sum appears in the same cycle at the output.
- Handshake:
  - Single global advance: adv = !out_valid | out_ready.
  - in_ready = adv; the input transfer happens when in_valid & in_ready.
  - When adv=1, all stages shift by one; stage 0 loads the new operands, or a bubble (valid=0) if in_valid=0.
  - When adv=0, all registers hold, including bubbles.
  - Outputs remain stable while out_valid & !out_ready.
  - Throughput is one operation per cycle when out_ready is held at 1.
  - Output transfer happens when out_valid & out_ready.
- Flags:
  - Computed in the last stage from the final segment's carries plus the accumulated zero-detect.
  - The zero-detect is an AND of per-segment "segment==0" bits carried down the pipeline.
  - Flags are registered together with sum.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH; no saturation.
  - In add mode with c_in=1, the result is a+b+1.
- Simultaneous events:
  - An input accept and an output drain in the same cycle are both honoured.
  - rst_n low overrides everything.

Test Plan:
- Carry ripple across all segments, WIDTH=32, add: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> after 2 cycles sum=0x00000000, c_out=1, zero=1, ovf=0, neg=0.
- Signed overflow, add: a=0x7FFFFFFF, b=1, c_in=0 -> sum=0x80000000, ovf=1, neg=1, c_out=0.
- Subtract with borrow, sub=1: a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, neg=1, ovf=0. Subtract without borrow: a=7, b=5 -> sum=2, c_out=1.
- Throughput: 8 back-to-back operations with in_valid=1 and out_ready=1 -> results appear in order on 8 consecutive cycles, each exactly 2 cycles after its input, in_ready constantly 1.
- Backpressure:
  - Setup: out_ready=0 for 3 cycles while feeding operations.
  - Response: in_ready drops once the pipeline is full; out_valid, sum and the flags are held stable.
  - Recovery: after out_ready=1 all results drain in order, with no loss or duplication.
- Reset mid-flight: rst_n=0 for one cycle while 2 operations are in flight -> out_valid=0 and all outputs 0 next cycle; neither result ever emerges. Also run WIDTH=64 (4 stages): a=0x00000000FFFFFFFF, b=1 -> sum=0x0000000100000000 after 4 cycles.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is cut
//   into 16-bit segments, and each segment is handled by its own pipeline
//   stage. Each stage is built from a four-group CLA with a lookahead unit.
//   The carry between segments is registered. Operand bits for later segments
//   ride along in skew registers. Finished sum segments ride along in deskew
//   registers, so the whole result leaves the last stage at once.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; clears valid bits and all data
//   in_valid  a, b, sub and c_in carry an operation this cycle
//   in_ready  block can take an operation this cycle (global advance)
//   a, b      operands (WIDTH bits)
//   sub       0: a + b + c_in, 1: a - b (a + ~b + 1, c_in ignored)
//   c_in      carry-in for add mode
//   out_valid result registers hold a live result
//   out_ready downstream takes the result this cycle
//   sum       WIDTH-bit result, modulo 2^WIDTH
//   c_out     carry out of the MSB (in subtract mode 1 means no borrow)
//   ovf       signed overflow, carry into MSB xor carry out of MSB
//   zero      sum == 0
//   neg       sum[WIDTH-1]
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NS = WIDTH / SEG;

  // 16-bit CLA. It has four 4-bit groups, and each group produces a group
  // generate and a group propagate. The lookahead unit turns those into group
  // carries. The result is {carry_out, sum[15:0]}.
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & gc[0]);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & gc[0]);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
    for (int j = 0; j < 4; j++) begin
      c[4*j] = gc[j];
      for (int i = 0; i < 3; i++) begin
        c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
      end
    end
    return {gc[4], p ^ c};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Every stage moves together. A held result at the output freezes the whole
  // pipe, and this includes any bubbles.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  // Subtraction is a + ~b + 1. The inversion is applied once, at capture.
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [SEG-1:0]       seg_a, seg_b;
    logic                 seg_cin, seg_zin, valid_in;
    logic [SEG:0]         seg_r;
    logic [SEG*(k+1)-1:0] psum_in, psum_q, psum_d;
    logic                 valid_q, valid_d, carry_q, carry_d, zero_q, zero_d;

    // Stage 0 takes its inputs straight from the ports. Later stages take them
    // from the previous stage's skew registers and registered carry.
    if (k == 0) begin : g_src
      assign seg_a    = a[SEG-1:0];
      assign seg_b    = b_eff[SEG-1:0];
      assign seg_cin  = sub | c_in;
      assign seg_zin  = 1'b1;
      assign valid_in = in_valid;
      assign psum_in  = seg_r[SEG-1:0];
    end else begin : g_src
      assign seg_a    = g_stage[k-1].g_skew.skew_a_q[SEG-1:0];
      assign seg_b    = g_stage[k-1].g_skew.skew_b_q[SEG-1:0];
      assign seg_cin  = g_stage[k-1].carry_q;
      assign seg_zin  = g_stage[k-1].zero_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign psum_in  = {seg_r[SEG-1:0], g_stage[k-1].psum_q};
    end

    assign seg_r = cla16(seg_a, seg_b, seg_cin);

    // Zero-detect is ANDed segment by segment as the operation moves down
    // the pipe.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      psum_d  = psum_q;
      if (adv) begin
        valid_d = valid_in;
        carry_d = seg_r[SEG];
        zero_d  = seg_zin & (seg_r[SEG-1:0] == '0);
        psum_d  = psum_in;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        zero_q  <= 1'b0;
        psum_q  <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
        psum_q  <= psum_d;
      end
    end

    // Skew registers hold the operand bits of the segments that are not yet
    // computed. Each stage drops the 16 bits it has consumed.
    if (k < NS-1) begin : g_skew
      localparam int SW = WIDTH - SEG*(k+1);
      logic [SW-1:0] skew_a_q, skew_a_d, skew_b_q, skew_b_d, skew_a_in, skew_b_in;

      if (k == 0) begin : g_in
        assign skew_a_in = a[WIDTH-1:SEG];
        assign skew_b_in = b_eff[WIDTH-1:SEG];
      end else begin : g_in
        assign skew_a_in = g_stage[k-1].g_skew.skew_a_q[WIDTH-SEG*k-1:SEG];
        assign skew_b_in = g_stage[k-1].g_skew.skew_b_q[WIDTH-SEG*k-1:SEG];
      end

      always_comb begin
        skew_a_d = skew_a_q;
        skew_b_d = skew_b_q;
        if (adv) begin
          skew_a_d = skew_a_in;
          skew_b_d = skew_b_in;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          skew_a_q <= '0;
          skew_b_q <= '0;
        end else begin
          skew_a_q <= skew_a_d;
          skew_b_q <= skew_b_d;
        end
      end
    end

    // The carry into the MSB is recovered from the MSB sum bit and its two
    // operand bits. This avoids exporting an extra carry from the CLA.
    if (k == NS-1) begin : g_last
      logic ovf_q, ovf_d, c_msb_in;
      assign c_msb_in = seg_r[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];

      always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = c_msb_in ^ seg_r[SEG];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_stage[NS-1].valid_q;
  assign sum       = g_stage[NS-1].psum_q;
  assign c_out     = g_stage[NS-1].carry_q;
  assign zero      = g_stage[NS-1].zero_q;
  assign ovf       = g_stage[NS-1].g_last.ovf_q;
  assign neg       = sum[WIDTH-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub
//   Scoreboard bench for cla_pipe_addsub. It drives two instances, one with
//   WIDTH=32 (2 stages) and one with WIDTH=64 (4 stages). Expected results
//   come from a plain arithmetic model. Each is queued when an operation is
//   accepted and compared when the matching result is drained.
module tb_cla_pipe_addsub;

  typedef struct {
    logic [63:0] sum;
    logic        c_out, ovf, zero, neg;
    int          stamp;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, out_ready;
  logic        iv32, ir32, ov32, sub32, cin32, co32, ovf32, z32, n32;
  logic [31:0] a32, b32, sum32;
  logic        iv64, ir64, ov64, sub64, cin64, co64, ovf64, z64, n64;
  logic [63:0] a64, b64, sum64;

  int   n_checks = 0, n_fail = 0, cyc = 0, stall_cycles = 0;
  int   n_in32 = 0, n_out32 = 0;
  bit   lat_on = 1'b0, saw_full = 1'b0, prev_stall = 1'b0;
  logic [31:0] held_sum;
  logic [3:0]  held_flags;
  exp_t q32[$], q64[$];

  cla_pipe_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub32), .c_in(cin32), .out_valid(ov32), .out_ready(out_ready), .sum(sum32),
    .c_out(co32), .ovf(ovf32), .zero(z32), .neg(n32)
  );

  cla_pipe_addsub #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .sub(sub64), .c_in(cin64), .out_valid(ov64), .out_ready(out_ready), .sum(sum64),
    .c_out(co64), .ovf(ovf64), .zero(z64), .neg(n64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic: a plain wide add. Overflow uses the sign rule
  // (operands of equal sign giving a result of the other sign).
  function automatic exp_t model(input logic [63:0] ta, input logic [63:0] tb,
                                 input logic ts, input logic tc, input int w);
    exp_t        e;
    logic [64:0] mask, full;
    logic [63:0] bb;
    logic        ci;
    mask    = (65'd1 << w) - 65'd1;
    bb      = ts ? ~tb : tb;
    ci      = ts ? 1'b1 : tc;
    full    = ({1'b0, ta} & mask) + ({1'b0, bb} & mask) + {64'd0, ci};
    e.sum   = full[63:0] & mask[63:0];
    e.c_out = full[w];
    e.neg   = e.sum[w-1];
    e.zero  = (e.sum == 64'd0);
    e.ovf   = (ta[w-1] == bb[w-1]) && (e.neg != ta[w-1]);
    e.stamp = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic checkResult(input string p, input exp_t e, input logic [63:0] s,
                             input logic co, input logic ov, input logic z, input logic ng,
                             input int lat, input int ns);
    checkOutput({p, "_sum"}, s, e.sum);
    checkOutput({p, "_flags(cout,ovf,zero,neg)"}, {60'd0, co, ov, z, ng},
                {60'd0, e.c_out, e.ovf, e.zero, e.neg});
    if (e.chk_lat) checkOutput({p, "_latency"}, 64'(lat), 64'(ns));
  endtask

  // Looks at the handshakes in the middle of each cycle. Both transfers
  // happen at the next rising edge unless reset is being applied.
  task automatic monitorCycle();
    exp_t e;
    if (!rst_n) begin
      q32.delete();
      q64.delete();
      prev_stall = 1'b0;
    end else begin
      if (ov32 && out_ready) begin
        n_out32++;
        if (q32.size() == 0) checkOutput("out32_unexpected", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          checkResult("r32", e, {32'd0, sum32}, co32, ovf32, z32, n32, cyc - e.stamp, 2);
        end
      end
      if (ov64 && out_ready) begin
        if (q64.size() == 0) checkOutput("out64_unexpected", 64'd1, 64'd0);
        else begin
          e = q64.pop_front();
          checkResult("r64", e, sum64, co64, ovf64, z64, n64, cyc - e.stamp, 4);
        end
      end
      if (iv32 && ir32) begin
        e = model({32'd0, a32}, {32'd0, b32}, sub32, cin32, 32);
        e.stamp = cyc;
        e.chk_lat = lat_on;
        q32.push_back(e);
        n_in32++;
      end
      if (iv64 && ir64) begin
        e = model(a64, b64, sub64, cin64, 64);
        e.stamp = cyc;
        e.chk_lat = lat_on;
        q64.push_back(e);
      end
      if (ov32 && !out_ready) begin
        if (!ir32) saw_full = 1'b1;
        if (prev_stall) begin
          checkOutput("hold_sum", {32'd0, sum32}, {32'd0, held_sum});
          checkOutput("hold_flags", {60'd0, co32, ovf32, z32, n32}, {60'd0, held_flags});
        end
        held_sum   = sum32;
        held_flags = {co32, ovf32, z32, n32};
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    monitorCycle();
  end

  // These tasks are called just after a rising edge. Each one returns just
  // after the edge that accepted the operation.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                               input logic ts, input logic tc);
    int n = 0;
    a32 = ta; b32 = tb; sub32 = ts; cin32 = tc; iv32 = 1'b1;
    @(negedge clk);
    while (!ir32 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ir32) checkOutput("accept32_timeout", 64'd0, 64'd1);
    stall_cycles += n;
    @(posedge clk);
    #1 iv32 = 1'b0;
  endtask

  task automatic applyStimulus64(input logic [63:0] ta, input logic [63:0] tb,
                                 input logic ts, input logic tc);
    int n = 0;
    a64 = ta; b64 = tb; sub64 = ts; cin64 = tc; iv64 = 1'b1;
    @(negedge clk);
    while (!ir64 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ir64) checkOutput("accept64_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 iv64 = 1'b0;
  endtask

  task automatic idleDrain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_q32_empty", 64'(q32.size()), 64'd0);
    checkOutput("drain_q64_empty", 64'(q64.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int out_before;
    rst_n = 1'b0; out_ready = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; cin32 = 1'b0;
    iv64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; cin64 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid32", {63'd0, ov32}, 64'd0);
    checkOutput("rst_sum32", {32'd0, sum32}, 64'd0);
    checkOutput("rst_flags32", {60'd0, co32, ovf32, z32, n32}, 64'd0);
    checkOutput("rst_out_valid64", {63'd0, ov64}, 64'd0);
    checkOutput("rst_sum64", sum64, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {63'd0, ir32}, 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases, then a back-to-back random burst
    lat_on = 1'b1;
    stall_cycles = 0;
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b0);
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b0);
    applyStimulus(32'h0000_1234, 32'h1, 1'b0, 1'b1);
    applyStimulus(32'd9, 32'd9, 1'b1, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idleDrain();
    checkOutput("throughput_stalls", 64'(stall_cycles), 64'd0);

    // Backpressure: hold the output for 3 cycles once the pipe is full
    lat_on = 1'b0;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        int n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!ov32 && n < 10) begin
          n++;
          @(negedge clk);
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idleDrain();
    checkOutput("in_ready_dropped_when_full", {63'd0, saw_full}, 64'd1);
    checkOutput("no_loss_or_dup", 64'(n_out32), 64'(n_in32));

    // Reset while two operations are in flight and the output is held
    out_ready = 1'b0;
    applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    applyStimulus(32'h3333_3333, 32'h0000_0001, 1'b1, 1'b0);
    out_before = n_out32;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", {63'd0, ov32}, 64'd0);
    checkOutput("midrst_sum", {32'd0, sum32}, 64'd0);
    checkOutput("midrst_flags", {60'd0, co32, ovf32, z32, n32}, 64'd0);
    repeat (6) @(posedge clk);
    checkOutput("midrst_discarded", 64'(n_out32), 64'(out_before));
    #1;

    // Four-stage instance
    lat_on = 1'b1;
    applyStimulus64(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    applyStimulus64(64'h0, 64'h1, 1'b1, 1'b0);
    applyStimulus64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    applyStimulus64(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus64({$urandom(), $urandom()}, {$urandom(), $urandom()},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idleDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
